// File: rtl/elevator_scheduler.sv
// SCAN-style collective scheduler for a single elevator car: latches floor calls,
// picks the next target in the travel direction and sequences move / stop / door phases.
module elevator_scheduler #(
  parameter int FLOORS      = 16,
  parameter int DOOR_CYCLES = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [FLOORS-1:0] i_call_req,
  input  logic [3:0]        i_current_floor,
  input  logic              i_at_floor,
  input  logic              i_calc_en,
  input  logic              i_calc_up_down,
  output logic [3:0]        o_target_floor,
  output logic              o_motor_en,
  output logic              o_motor_dir,
  output logic              o_door_open,
  output logic [FLOORS-1:0] o_pending,
  output logic              o_busy
);

  localparam int CW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]     DOOR_LOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONE_HOT0  = FLOORS'(1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            r_state, w_next;
  logic [FLOORS-1:0] r_pending, w_clear;
  logic [3:0]        r_target, w_target_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_door_open;
  logic [CW-1:0]     r_door_cnt, w_cnt_nxt;
  logic              w_up_hit, w_dn_hit;
  logic [3:0]        w_up_floor, w_dn_floor;
  logic              w_in_range, w_here, w_recall;

  assign w_in_range = int'(i_current_floor) < FLOORS;
  assign w_here     = w_in_range && r_pending[i_current_floor];
  assign w_recall   = w_in_range && i_call_req[i_current_floor];

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    w_up_hit   = 1'b0;
    w_up_floor = '0;
    w_dn_hit   = 1'b0;
    w_dn_floor = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(i_current_floor))) begin
        w_up_hit   = 1'b1;
        w_up_floor = 4'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i < int'(i_current_floor))) begin
        w_dn_hit   = 1'b1;
        w_dn_floor = 4'(i);
      end
    end
  end

  always_comb begin
    w_target_nxt = r_target;
    w_dir_nxt    = r_dir;
    if (r_dir) begin
      if (w_up_hit) begin
        w_target_nxt = w_up_floor;
      end else if (w_dn_hit) begin
        w_target_nxt = w_dn_floor;
        w_dir_nxt    = 1'b0;
      end
    end else begin
      if (w_dn_hit) begin
        w_target_nxt = w_dn_floor;
      end else if (w_up_hit) begin
        w_target_nxt = w_up_floor;
        w_dir_nxt    = 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_door_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_here && i_at_floor) begin
          w_next    = S_DOOR;
          w_cnt_nxt = DOOR_LOAD;
        end else if (|r_pending) begin
          w_next = S_MOVE;
        end
      end
      S_MOVE: begin
        if (w_here && i_at_floor) begin
          w_next    = S_DOOR;
          w_cnt_nxt = DOOR_LOAD;
        end else if (!i_calc_en) begin
          w_next = S_IDLE;
        end
      end
      S_DOOR: begin
        if (w_recall) begin
          w_cnt_nxt = DOOR_LOAD;
        end else if (r_door_cnt == '0) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_nxt = r_door_cnt - 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Calls for the floor being served are absorbed while the door is (or becomes) open.
  assign w_clear = ((w_next == S_DOOR) && w_in_range) ? (ONE_HOT0 << i_current_floor) : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_target    <= '0;
      r_dir       <= 1'b1;
      r_door_open <= 1'b0;
      r_door_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_pending   <= (r_pending | i_call_req) & ~w_clear;
      r_door_open <= (w_next == S_DOOR);
      r_door_cnt  <= w_cnt_nxt;
      if (r_state != S_DOOR) begin
        r_target <= w_target_nxt;
        r_dir    <= w_dir_nxt;
      end
    end
  end

  assign o_target_floor = r_target;
  assign o_motor_en     = (r_state == S_MOVE) && i_calc_en;
  assign o_motor_dir    = (r_state == S_MOVE) && i_calc_up_down;
  assign o_door_open    = r_door_open;
  assign o_pending      = r_pending;
  assign o_busy         = (r_state != S_IDLE) || (|r_pending);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomized bench: a simple car/calculator environment drives the scheduler and a
// phase-level reference model predicts every output each cycle.
module tb_elevator_scheduler;
  localparam int FL = 16;
  localparam int DC = 8;
  localparam int P_IDLE = 0, P_MOVE = 1, P_DOOR = 2;
  localparam int N_CYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] call;
  logic [3:0]  cur;
  logic        atf, cen, cud;
  logic [3:0]  o_target_floor;
  logic        o_motor_en, o_motor_dir, o_door_open, o_busy;
  logic [15:0] o_pending;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          ph, mt, opened, deadline;
  logic [15:0] mp;
  logic        md;
  // car model
  int          travel;
  logic        prev_men, prev_mdir;

  elevator_scheduler #(.FLOORS(FL), .DOOR_CYCLES(DC)) dut (
    .i_clock(clk), .i_reset(rst), .i_call_req(call), .i_current_floor(cur),
    .i_at_floor(atf), .i_calc_en(cen), .i_calc_up_down(cud),
    .o_target_floor(o_target_floor), .o_motor_en(o_motor_en), .o_motor_dir(o_motor_dir),
    .o_door_open(o_door_open), .o_pending(o_pending), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int nph, c, up, dn;
    logic here, recall, ce;
    logic [15:0] np;
    if (rst) begin
      ph = P_IDLE; mp = '0; mt = 0; md = 1'b1; opened = 0; deadline = 0;
      return;
    end
    c      = int'(cur);
    ce     = (mt != c);
    here   = mp[cur];
    recall = call[cur];
    nph    = ph;
    case (ph)
      P_IDLE: if (here && atf) nph = P_DOOR; else if (mp != 0) nph = P_MOVE;
      P_MOVE: if (here && atf) nph = P_DOOR; else if (!ce) nph = P_IDLE;
      default: begin
        if (recall) deadline = opened + DC;
        if (opened >= deadline) nph = P_IDLE;
        else opened++;
      end
    endcase
    if (nph == P_DOOR && ph != P_DOOR) begin
      opened = 1;
      deadline = DC;
    end
    if (ph != P_DOOR) begin
      up = -1;
      dn = -1;
      for (int d = 1; c + d < FL; d++) if (mp[c+d]) begin up = c + d; break; end
      for (int d = 1; c - d >= 0; d++) if (mp[c-d]) begin dn = c - d; break; end
      if (md) begin
        if (up >= 0) mt = up;
        else if (dn >= 0) begin mt = dn; md = 1'b0; end
      end else begin
        if (dn >= 0) mt = dn;
        else if (up >= 0) begin mt = up; md = 1'b1; end
      end
    end
    np = mp | call;
    if (nph == P_DOOR) np[cur] = 1'b0;
    mp = np;
    ph = nph;
  endtask

  initial begin
    int r;
    logic exp_men, exp_mdir;
    rst = 1'b1; call = 16'h0010; cur = 4'd0; atf = 1'b1; cen = 1'b0; cud = 1'b0;
    travel = 0; prev_men = 1'b0; prev_mdir = 1'b0;
    ph = P_IDLE; mp = '0; mt = 0; md = 1'b1; opened = 0; deadline = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      // new stimulus for this cycle
      rst = (cyc < 1) || ($urandom_range(0, 599) == 0);
      if (cyc < 1) call = 16'h0010;
      else begin
        r = $urandom_range(0, 99);
        if (r < 8)                        call = 16'h1 << $urandom_range(0, 15);
        else if (r < 10)                  call = 16'($urandom) & 16'($urandom);
        else if (r < 14 && ph == P_DOOR)  call = 16'h1 << cur;
        else                              call = '0;
      end
      if (prev_men) begin
        travel++;
        if (travel == 3) begin
          if (prev_mdir && cur != 4'd15) cur = cur + 4'd1;
          else if (!prev_mdir && cur != 4'd0) cur = cur - 4'd1;
          travel = 0;
        end
      end
      if (rst) travel = 0;
      atf = (travel != 2);
      cen = (mt != int'(cur));
      cud = (mt > int'(cur));
      #1;
      exp_men  = (ph == P_MOVE) && (mt != int'(cur));
      exp_mdir = (ph == P_MOVE) && (mt > int'(cur));
      chk("target_floor", 32'(o_target_floor), 32'(mt));
      chk("motor_en", 32'(o_motor_en), 32'(exp_men));
      chk("motor_dir", 32'(o_motor_dir), 32'(exp_mdir));
      chk("door_open", 32'(o_door_open), 32'(ph == P_DOOR));
      chk("pending", 32'(o_pending), 32'(mp));
      chk("busy", 32'(o_busy), 32'((ph != P_IDLE) || (mp != 0)));
      prev_men  = exp_men;
      prev_mdir = exp_mdir;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Collective (SCAN-style) request scheduler for a single elevator car with up to 16 floors. It latches floor calls and picks the next target floor. It drives the combinational up/down calculator's floor input and sequences the car through move, stop and door-open phases. It sits between the call-button/floor-sensor inputs and the motor driver; the calculator's `en`/`up_down` results are fed back into it and gated onto the motor outputs.

## Interface
- `FLOORS`, 16: number of floors served; floors 0..FLOORS-1; max 16 (4-bit floor code).
- `DOOR_CYCLES`, 8: clock cycles the door stays open per stop; must be ≥ 2.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `call_req` in FLOORS: call pulses, bit i = request for floor i; any number of bits may be set in the same cycle.
- `current_floor` in 4: floor code from the floor sensor.
- `at_floor` in 1: car is level with `current_floor`; only then may it stop.
- `calc_en` in 1: calculator result, target ≠ current.
- `calc_up_down` in 1: calculator result, 1 = up.
- `target_floor` out 4: registered; drives the calculator's requested-floor input.
- `motor_en` out 1: motor enable.
- `motor_dir` out 1: motor direction, 1 = up.
- `door_open` out 1: registered door command.
- `pending` out FLOORS: latched outstanding requests.
- `busy` out 1: high when state ≠ IDLE or `pending` ≠ 0.

## Operation
- **States:** IDLE, MOVE, DOOR.
- **Request latch:** each cycle, `pending <= (pending | call_req) & ~clear_mask`.
  - `clear_mask` is the one-hot of `current_floor` on a cycle that enters or remains in DOOR; otherwise it is 0.
  - A call for the floor being served is absorbed, not latched.
- **Direction register `dir`:** reset value 1 (up).
- **Target selection:** combinational over `pending` and `current_floor`, registered into `target_floor` every cycle in IDLE and MOVE.
  - If `dir` = 1: the lowest pending floor > `current_floor`.
  - If none exists, the highest pending floor < `current_floor`, and `dir` flips to 0 on the same edge.
  - `dir` = 0 is symmetric: the highest pending floor below, else the lowest pending floor above.
  - If no pending floor other than the current one exists, `target_floor` holds its value.
- **IDLE:**
  - `pending[current_floor]` & `at_floor` → DOOR.
  - Else `pending` ≠ 0 → MOVE.
  - Else stay in IDLE.
- **MOVE:**
  - `motor_en` = `calc_en`; `motor_dir` = `calc_up_down`.
  - The target is re-evaluated every cycle, so a newer call that lies nearer in the travel direction pre-empts the current target.
  - `at_floor` & `pending[current_floor]` → DOOR. This is a stop on the way; it need not be the target.
  - `calc_en` = 0 with nothing pending at the current floor → IDLE.
- **DOOR:**
  - `motor_en` = 0; door counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - A `call_req` for `current_floor` during DOOR reloads the counter (door held open).
  - Counter = 0 → IDLE.
- **Motor outputs:** `motor_en` = (state == MOVE) & `calc_en`, combinational; `motor_dir` = `calc_up_down` in MOVE, else 0.
- **Out-of-range input:** `call_req` bits and `current_floor` values ≥ FLOORS are ignored (treated as no request / no match).

## Timing
- **Reset values:** state IDLE, `pending` 0, `target_floor` 0, `dir` 1, `door_open` 0, `motor_en` 0, `motor_dir` 0, `busy` 0, door counter 0.
- **Reset mid-operation:** every register returns to its reset value at the next edge. The motor stops in that cycle because `motor_en` decodes the state. Latched calls are lost.
- **Call latency:**
  - `call_req` at edge n → `pending` bit set after edge n.
  - `target_floor` updated after edge n+1.
  - `motor_en` valid combinationally in the same cycle as `target_floor`.
- **Stopping:** MOVE → DOOR on the edge where `at_floor` & `pending[current_floor]` is sampled. `motor_en` is 0 from the following cycle; `door_open` is 1 from the following cycle.
- **Door duration:** `door_open` is high for exactly DOOR_CYCLES cycles when no re-call occurs.
- **Re-call:** a re-call in door-open cycle k extends the opening to k + DOOR_CYCLES cycles.
- **Simultaneous events:**
  - Set and clear of the same `pending` bit on the same edge: the clear wins.
  - Calls for other floors are never lost.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `call_req` = 0x0010.
  → all outputs hold their reset values, and `pending` = 0 after the release.
- **Single call up:** car at floor 0 with `at_floor`=1; pulse `call_req`[5].
  → `target_floor`=5 two cycles later; `motor_en`=1 and `motor_dir`=1 while `current_floor` steps 1..4.
  → At floor 5 with `at_floor`: `door_open` high for 8 cycles, `pending`=0, return to IDLE.
- **Collective stop:** car moving up from 2 toward 9; pulse `call_req`[6] while at floor 4.
  → The car stops at 6 (`door_open` 8 cycles, bit 6 cleared), then resumes to 9.
- **Reversal:** car at 7 with `dir`=1, pending = {3, 10}.
  → Serves 10 first; `dir` flips to 0 there; then serves 3.
- **Door hold:** during DOOR at floor 4, pulse `call_req`[4] in door-open cycle 5.
  → `door_open` lasts 13 cycles total, and `pending`[4] stays 0.
- **Reset mid-move:** assert `reset` while MOVE toward 12 with pending = {12, 14}.
  → `motor_en`=0 the next cycle, `pending`=0, state IDLE.
